// File: rtl/router_pkg.sv
// Shared sizing helpers for the buffered router and its per-output FIFOs.
package router_pkg;

  localparam int DROP_W = 8;

  function automatic int addr_w(input int n_outputs);
    return $clog2(n_outputs);
  endfunction

  function automatic int pay_w(input int n_bits, input int n_outputs);
    return n_bits - $clog2(n_outputs);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Circular-buffer FIFO with wrap-at-depth pointers so any depth >= 2 works.
module router_fifo
  import router_pkg::*;
#(
  parameter int p_width = 5,
  parameter int p_depth = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enq_val,
  output logic                        enq_rdy,
  input  logic [p_width-1:0]          enq_msg,
  output logic                        deq_val,
  input  logic                        deq_rdy,
  output logic [p_width-1:0]          deq_msg,
  output logic [cnt_w(p_depth)-1:0]   count
);

  localparam int CNT_W = cnt_w(p_depth);
  localparam int PTR_W = $clog2(p_depth);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(p_depth);
  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(p_depth - 1);

  logic [p_width-1:0] mem_r [p_depth];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               enq_fire_s;
  logic               deq_fire_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_C) ? '0 : ptr + 1'b1;
  endfunction

  // Ready depends only on stored state so upstream decode never loops through enq_val.
  assign enq_rdy    = (count_r != FULL_C);
  assign deq_val    = (count_r != '0);
  assign enq_fire_s = enq_val & enq_rdy;
  assign deq_fire_s = deq_val & deq_rdy;
  assign deq_msg    = mem_r[rd_ptr_r];
  assign count      = count_r;

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_fire_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (deq_fire_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (enq_fire_s) begin
      mem_r[wr_ptr_r] <= enq_msg;
    end
  end

  router_fifo_chk #(
    .p_width (p_width),
    .p_depth (p_depth),
    .p_cnt_w (CNT_W)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .deq_val (deq_val),
    .deq_rdy (deq_rdy),
    .deq_msg (deq_msg),
    .count   (count_r)
  );

endmodule

// File: rtl/router_fifo_chk.sv
// Invariants of a single router FIFO: occupancy bound and head stability under backpressure.
module router_fifo_chk #(
  parameter int p_width = 5,
  parameter int p_depth = 4,
  parameter int p_cnt_w = 3
) (
  input logic               clk,
  input logic               reset,
  input logic               deq_val,
  input logic               deq_rdy,
  input logic [p_width-1:0] deq_msg,
  input logic [p_cnt_w-1:0] count
);

  localparam logic [p_cnt_w-1:0] FULL_C = p_cnt_w'(p_depth);

  a_count_range: assert property (@(posedge clk) disable iff (!reset)
    count <= FULL_C);

  a_head_hold: assert property (@(posedge clk) disable iff (!reset)
    (deq_val && !deq_rdy) |=> (deq_val && $stable(deq_msg)));

endmodule

// File: rtl/router_buffered.sv
// 1-to-N router: top address bits select an output FIFO, the rest is queued payload.
module router_buffered
  import router_pkg::*;
#(
  parameter int p_nbits    = 8,
  parameter int p_noutputs = 8,
  parameter int p_depth    = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          valid,
  output logic                                          ready_out,
  input  logic [p_nbits-1:0]                            message_in,
  output logic [p_noutputs-1:0]                         valid_out,
  input  logic [p_noutputs-1:0]                         ready,
  output logic [pay_w(p_nbits, p_noutputs)*p_noutputs-1:0] message_out,
  output logic [cnt_w(p_depth)*p_noutputs-1:0]          occupancy,
  output logic [DROP_W-1:0]                             drop_count
);

  localparam int ADDR_W = addr_w(p_noutputs);
  localparam int PAY_W  = pay_w(p_nbits, p_noutputs);
  localparam int CNT_W  = cnt_w(p_depth);
  localparam logic [ADDR_W:0]   NOUT_C     = (ADDR_W + 1)'(p_noutputs);
  localparam logic [DROP_W-1:0] DROP_MAX_C = '1;

  logic [ADDR_W-1:0]     addr_s;
  logic [PAY_W-1:0]      payload_s;
  logic                  in_range_s;
  logic [p_noutputs-1:0] full_s;
  logic [p_noutputs-1:0] enq_rdy_s;
  logic [p_noutputs-1:0] enq_val_s;
  logic [DROP_W-1:0]     drop_r;

  // Address decode and per-address accept; out-of-range is always accepted and dropped.
  always_comb begin
    addr_s     = message_in[p_nbits-1 -: ADDR_W];
    payload_s  = message_in[PAY_W-1:0];
    in_range_s = ({1'b0, addr_s} < NOUT_C);
    ready_out  = 1'b1;
    if (in_range_s) begin
      ready_out = !full_s[addr_s];
    end else begin
      ready_out = 1'b1;
    end
  end

  // Enqueue demux; each FIFO gates the request with its own full flag.
  always_comb begin
    enq_val_s = '0;
    if (in_range_s) begin
      enq_val_s[addr_s] = valid;
    end else begin
      enq_val_s = '0;
    end
  end

  // Saturating count of discarded out-of-range messages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_r <= '0;
    end else if (valid && !in_range_s && (drop_r != DROP_MAX_C)) begin
      drop_r <= drop_r + 1'b1;
    end else begin
      drop_r <= drop_r;
    end
  end

  assign drop_count = drop_r;

  for (genvar i = 0; i < p_noutputs; i++) begin : g_out
    router_fifo #(
      .p_width (PAY_W),
      .p_depth (p_depth)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .enq_val (enq_val_s[i]),
      .enq_rdy (enq_rdy_s[i]),
      .enq_msg (payload_s),
      .deq_val (valid_out[i]),
      .deq_rdy (ready[i]),
      .deq_msg (message_out[i*PAY_W +: PAY_W]),
      .count   (occupancy[i*CNT_W +: CNT_W])
    );
    assign full_s[i] = !enq_rdy_s[i];
  end

endmodule

// File: tb/tb_router_buffered.sv
// Scoreboard bench: default 8x4 router plus a 6-output, depth-3 router for drops and reset.
module tb_router_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Router A: p_nbits=8, p_noutputs=8, p_depth=4 (PAY_W=5, CNT_W=3)
  logic        a_rst_n, a_valid, a_rdy_out;
  logic [7:0]  a_msg, a_vout, a_ready, a_drop;
  logic [39:0] a_mout;
  logic [23:0] a_occ;
  logic [4:0]  qa [8][$];
  bit   [7:0]  a_pop;
  int          a_drop_m = 0;

  // Router B: p_nbits=8, p_noutputs=6, p_depth=3 (PAY_W=5, CNT_W=2)
  logic        b_rst_n, b_valid, b_rdy_out;
  logic [7:0]  b_msg, b_drop;
  logic [5:0]  b_vout, b_ready;
  logic [29:0] b_mout;
  logic [11:0] b_occ;
  logic [4:0]  qb [6][$];
  bit   [5:0]  b_pop;
  int          b_drop_m = 0;

  router_buffered #(.p_nbits(8), .p_noutputs(8), .p_depth(4)) dut_a (
    .clk(clk), .reset(a_rst_n), .valid(a_valid), .ready_out(a_rdy_out),
    .message_in(a_msg), .valid_out(a_vout), .ready(a_ready),
    .message_out(a_mout), .occupancy(a_occ), .drop_count(a_drop));

  router_buffered #(.p_nbits(8), .p_noutputs(6), .p_depth(3)) dut_b (
    .clk(clk), .reset(b_rst_n), .valid(b_valid), .ready_out(b_rdy_out),
    .message_in(b_msg), .valid_out(b_vout), .ready(b_ready),
    .message_out(b_mout), .occupancy(b_occ), .drop_count(b_drop));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor A: compare outputs against the model at negedge, retire dequeues at posedge.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a_pop[i] = 1'b0;
      chk($sformatf("a_valid_out[%0d]", i), int'(a_vout[i]), int'(qa[i].size() != 0));
      chk($sformatf("a_occupancy[%0d]", i), int'(a_occ[i*3 +: 3]), qa[i].size());
      if (a_vout[i] && a_ready[i] && qa[i].size() != 0) begin
        chk($sformatf("a_message_out[%0d]", i), int'(a_mout[i*5 +: 5]), int'(qa[i][0]));
        a_pop[i] = 1'b1;
      end
    end
    chk("a_drop_count", int'(a_drop), a_drop_m);
    @(posedge clk);
    for (int i = 0; i < 8; i++) if (a_pop[i]) void'(qa[i].pop_front());
  end

  // Monitor B: same scheme for the 6-output router.
  initial forever begin
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      b_pop[j] = 1'b0;
      chk($sformatf("b_valid_out[%0d]", j), int'(b_vout[j]), int'(qb[j].size() != 0));
      chk($sformatf("b_occupancy[%0d]", j), int'(b_occ[j*2 +: 2]), qb[j].size());
      if (b_vout[j] && b_ready[j] && qb[j].size() != 0) begin
        chk($sformatf("b_message_out[%0d]", j), int'(b_mout[j*5 +: 5]), int'(qb[j][0]));
        b_pop[j] = 1'b1;
      end
    end
    chk("b_drop_count", int'(b_drop), b_drop_m);
    @(posedge clk);
    for (int j = 0; j < 6; j++) if (b_pop[j]) void'(qb[j].pop_front());
  end

  // One cycle on router A; called at posedge+1, returns at the next posedge+1.
  task automatic a_cycle(input logic v, input logic [7:0] m, input logic [7:0] rdy);
    logic [2:0] ad;
    logic       acc;
    a_valid = v; a_msg = m; a_ready = rdy;
    ad = m[7:5];
    @(negedge clk); #1;
    acc = (qa[ad].size() < 4);
    chk("a_ready_out", int'(a_rdy_out), int'(acc));
    @(posedge clk);
    if (v && acc) qa[ad].push_back(m[4:0]);
    #1;
  endtask

  task automatic b_cycle(input logic v, input logic [7:0] m, input logic [5:0] rdy);
    logic [2:0] ad;
    logic       in_r, acc;
    b_valid = v; b_msg = m; b_ready = rdy;
    ad   = m[7:5];
    in_r = (ad < 3'd6);
    @(negedge clk); #1;
    if (in_r) acc = (qb[ad].size() < 3);
    else      acc = 1'b1;
    chk("b_ready_out", int'(b_rdy_out), int'(acc));
    @(posedge clk);
    if (v && in_r && acc) qb[ad].push_back(m[4:0]);
    else if (v && !in_r && b_drop_m < 255) b_drop_m++;
    #1;
  endtask

  initial begin
    a_rst_n = 1'b0; a_valid = 1'b0; a_msg = 8'h00; a_ready = 8'h00;
    b_rst_n = 1'b0; b_valid = 1'b0; b_msg = 8'h00; b_ready = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Idle: every address of A must be accepting.
    for (int k = 0; k < 8; k++) a_cycle(1'b0, {3'(k), 5'd0}, 8'h00);

    // 0xA5 -> output 5, payload 5; visible one cycle later, then drained.
    a_cycle(1'b1, 8'hA5, 8'h00);
    chk("a5_valid_out", int'(a_vout), 32'h20);
    chk("a5_slice5", int'(a_mout[25 +: 5]), 5);
    a_cycle(1'b0, 8'h00, 8'h20);
    chk("a5_drained", int'(a_vout), 0);

    // Fill FIFO 3 with 1..4; addr 3 then blocked, addr 6 still accepted.
    for (int p = 1; p <= 4; p++) a_cycle(1'b1, {3'd3, 5'(p)}, 8'h00);
    chk("fifo3_full_occ", int'(a_occ[9 +: 3]), 4);
    a_cycle(1'b1, {3'd3, 5'd9}, 8'h00);
    a_cycle(1'b1, {3'd6, 5'd7}, 8'h00);
    chk("fifo6_occ", int'(a_occ[18 +: 3]), 1);
    for (int k = 0; k < 5; k++) a_cycle(1'b0, 8'h00, 8'h48);

    // FIFO 2 full with dequeue and enqueue in the same cycle.
    for (int p = 0; p < 4; p++) a_cycle(1'b1, {3'd2, 5'(p + 20)}, 8'h00);
    a_cycle(1'b1, {3'd2, 5'd10}, 8'h04);
    chk("fifo2_after_deq", int'(a_occ[6 +: 3]), 3);
    a_cycle(1'b1, {3'd2, 5'd11}, 8'h00);
    chk("fifo2_refill", int'(a_occ[6 +: 3]), 4);
    for (int k = 0; k < 5; k++) a_cycle(1'b0, 8'h00, 8'h04);
    a_valid = 1'b0; a_ready = 8'h00;

    // Router B: out-of-range address 7 is accepted, dropped and counted.
    for (int k = 0; k < 10; k++) b_cycle(1'b1, {3'd7, 5'(k)}, 6'h00);
    chk("b_drop_10", int'(b_drop), 10);
    chk("b_occ_empty", int'(b_occ), 0);
    for (int k = 0; k < 290; k++) b_cycle(1'b1, {3'd7, 5'(k)}, 6'h00);
    chk("b_drop_sat", int'(b_drop), 255);

    // Partly fill FIFOs 0, 1, 4 then reset mid-stream.
    for (int k = 0; k < 2; k++) begin
      b_cycle(1'b1, {3'd0, 5'(k + 1)}, 6'h00);
      b_cycle(1'b1, {3'd1, 5'(k + 3)}, 6'h00);
      b_cycle(1'b1, {3'd4, 5'(k + 5)}, 6'h00);
    end
    chk("b_pre_reset_occ", int'(b_occ), 12'h202 | 12'h008);
    b_valid = 1'b0;
    b_rst_n = 1'b0;
    for (int j = 0; j < 6; j++) qb[j].delete();
    b_drop_m = 0;
    #1;
    chk("b_reset_valid_out", int'(b_vout), 0);
    chk("b_reset_occ", int'(b_occ), 0);
    chk("b_reset_drop", int'(b_drop), 0);
    @(posedge clk); #1;
    b_rst_n = 1'b1;

    // Random traffic and backpressure after reset release.
    for (int k = 0; k < 300; k++)
      b_cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)));
    for (int k = 0; k < 8; k++) b_cycle(1'b0, 8'h00, 6'h3F);
    chk("b_final_empty", int'(b_vout), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
